// File: rtl/char_pkg.sv
// Shared types and constants for the character motion controller.
package char_pkg;

    // Vertical motion phases
    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } vstate_t;

    localparam logic [9:0] TILE        = 10'd32;
    localparam logic [9:0] MAX_X       = 10'd608;
    localparam logic [9:0] MAX_Y       = 10'd448;
    localparam logic [3:0] VY_MAX      = 4'd8;
    localparam logic [2:0] IDLE_FRAMES = 3'd4;
    localparam logic [2:0] WALK_FRAMES = 3'd6;

endpackage

// File: rtl/vsync_tick.sv
// Brings vsync into the clk domain and emits a one-cycle tick per rising edge.
// The detect uses a two-flop history so the tick is fully registered.
module vsync_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);

    logic [1:0] sync_q;
    logic [1:0] hist_q;

    // Two-flop synchroniser, registered history and registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            hist_q <= 2'b00;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], vsync};
            hist_q <= {hist_q[0], sync_q[1]};
            tick   <= hist_q[0] & ~hist_q[1];
        end
    end

endmodule

// File: rtl/char_motion_ctrl.sv
// Character motion controller: horizontal walking, jump/fall physics and
// sprite animation, all advanced once per frame tick while enabled.
// Optional feature: define CHAR_DOUBLE_JUMP_EN to allow one air jump per airtime.
module char_motion_ctrl
    import char_pkg::*;
#(
    parameter logic [9:0] START_X  = 10'd32,
    parameter logic [9:0] START_Y  = 10'd320,
    parameter int         ANIM_DIV = 6,
    parameter int         JUMP_V   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       enable,
    input  logic       respawn,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic [3:0] blk,
    output logic [9:0] img_x,
    output logic [9:0] img_y,
    output logic [2:0] frame_idx,
    output logic       is_moving,
    output logic       face_left,
    output logic       tick
);

    localparam logic [3:0] ANIM_LAST = 4'(ANIM_DIV - 1);
    localparam logic [3:0] JUMP_VY   = 4'(JUMP_V);

    logic        clear;
    logic        step;
    logic        move_left;
    logic        move_right;
    logic        moving_next;
    logic [9:0]  x_next;
    logic [9:0]  rise_y;
    logic [10:0] fall_sum;
    logic [2:0]  frame_last;
    logic [3:0]  anim_div;
    logic [3:0]  vy;
    logic        dj_fire;
    vstate_t     state;

    // Respawn behaves exactly like reset, including the tick generator
    assign clear = rst | respawn;
    assign step  = tick & enable;

    vsync_tick u_vsync_tick (
        .clk   (clk),
        .rst   (clear),
        .vsync (vsync),
        .tick  (tick)
    );

    // Resolve walking intent and the clamped next x position
    always_comb begin
        move_left   = btn_left & ~btn_right;
        move_right  = btn_right & ~btn_left;
        moving_next = move_left | move_right;
        x_next      = img_x;
        if (move_right && !blk[2]) begin
            x_next = (img_x >= MAX_X - 10'd2) ? MAX_X : img_x + 10'd2;
        end else if (move_left && !blk[3]) begin
            x_next = (img_x < 10'd2) ? 10'd0 : img_x - 10'd2;
        end
        rise_y     = (img_y >= {6'd0, vy}) ? img_y - {6'd0, vy} : 10'd0;
        fall_sum   = {1'b0, img_y} + {7'd0, vy};
        frame_last = is_moving ? WALK_FRAMES - 3'd1 : IDLE_FRAMES - 3'd1;
    end

`ifdef CHAR_DOUBLE_JUMP_EN
    logic jump_armed;
    logic jump_prev;

    // Track the last sampled jump level and whether the single air jump remains
    always_ff @(posedge clk) begin
        if (clear) begin
            jump_armed <= 1'b1;
            jump_prev  <= 1'b0;
        end else if (step) begin
            jump_prev <= btn_jump;
            if (state == GROUND) begin
                jump_armed <= 1'b1;
            end else if (dj_fire) begin
                jump_armed <= 1'b0;
            end
        end
    end

    assign dj_fire = jump_armed & btn_jump & ~jump_prev & (state != GROUND);
`else
    assign dj_fire = 1'b0;
`endif

    // Horizontal position, facing and animation sequencing
    always_ff @(posedge clk) begin
        if (clear) begin
            img_x     <= START_X;
            face_left <= 1'b0;
            is_moving <= 1'b0;
            frame_idx <= 3'd0;
            anim_div  <= 4'd0;
        end else if (step) begin
            img_x     <= x_next;
            is_moving <= moving_next;
            if (move_left) begin
                face_left <= 1'b1;
            end else if (move_right) begin
                face_left <= 1'b0;
            end
            if (moving_next != is_moving) begin
                frame_idx <= 3'd0;
                anim_div  <= 4'd0;
            end else if (anim_div >= ANIM_LAST) begin
                anim_div  <= 4'd0;
                frame_idx <= (frame_idx >= frame_last) ? 3'd0 : frame_idx + 3'd1;
            end else begin
                anim_div <= anim_div + 4'd1;
            end
        end
    end

    // Vertical FSM: ground, rising with decaying speed, falling with capped gravity
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= GROUND;
            vy    <= 4'd0;
            img_y <= START_Y;
        end else if (step) begin
            case (state)
                GROUND: begin
                    if (btn_jump) begin
                        state <= RISE;
                        vy    <= JUMP_VY;
                    end else if (!blk[0]) begin
                        state <= FALL;
                        vy    <= 4'd1;
                    end
                end
                RISE: begin
                    if (dj_fire) begin
                        vy <= JUMP_VY;
                    end else if (blk[1] || vy <= 4'd1) begin
                        state <= FALL;
                        vy    <= 4'd1;
                    end else begin
                        img_y <= rise_y;
                        vy    <= vy - 4'd1;
                    end
                end
                FALL: begin
                    if (dj_fire) begin
                        state <= RISE;
                        vy    <= JUMP_VY;
                    end else if (blk[0]) begin
                        state <= GROUND;
                        vy    <= 4'd0;
                        img_y <= {img_y[9:5], 5'b0};
                    end else if (fall_sum >= {1'b0, MAX_Y}) begin
                        state <= GROUND;
                        vy    <= 4'd0;
                        img_y <= MAX_Y;
                    end else begin
                        img_y <= fall_sum[9:0];
                        vy    <= (vy >= VY_MAX) ? VY_MAX : vy + 4'd1;
                    end
                end
                default: begin
                    state <= GROUND;
                    vy    <= 4'd0;
                end
            endcase
        end
    end

endmodule
